// File: rtl/axis_upsizer_if.sv
// Axis: valid/ready stream bundle, W-bit data, ok = valid & ready.
// Master drives valid/data, Slave drives ready.
interface Axis #(
  parameter int W = 1
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         ok;

  assign ok = valid & ready;

  modport Master (output valid, output data, input ready, input ok);
  modport Slave  (input valid, input data, input ok, output ready);
endinterface

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow beats (first beat = LSB lane) into one
// wide word behind a single output register; one beat per cycle sustained.
// Ports: rd_clk, rst (async active-low), in_stream (Axis.Slave, BITWIDTH),
//   out_stream (Axis.Master, RATIO*BITWIDTH).
// Macro AXIS_UPSIZE_FLUSH_EN adds flush (in) and out_beats (out) for
//   emitting partial words.
module axis_upsizer #(
  parameter int BITWIDTH = 1,
  parameter int RATIO    = 4
) (
  input  logic rd_clk,
  input  logic rst,
`ifdef AXIS_UPSIZE_FLUSH_EN
  input  logic flush,
  output logic [$clog2(RATIO+1)-1:0] out_beats,
`endif
  Axis.Slave   in_stream,
  Axis.Master  out_stream
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW = RATIO * BITWIDTH;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  generate
    if (RATIO < 1 || RATIO > 64) begin : g_bad_ratio
      $error("axis_upsizer: RATIO must be in 1..64");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_data;
  logic          r_valid;

  logic          w_last;
  logic          w_free;
  logic          w_in_ok;
  logic          w_out_ok;
  logic          w_ready;
  logic          w_load;
  logic          w_fl_go;
  logic [OW-1:0] w_acc_n;

  assign w_last   = (r_cnt == LAST);
  assign w_free   = ~r_valid | out_stream.ready;
  assign w_in_ok  = in_stream.ok;
  assign w_out_ok = out_stream.ok;

  // Accumulator with the current beat dropped into lane cnt; on the
  // final beat this is the complete word (top lane is never stored).
  always_comb begin
    w_acc_n = r_acc;
    if (w_in_ok)
      w_acc_n[int'(r_cnt)*BITWIDTH +: BITWIDTH] = in_stream.data;
  end

`ifdef AXIS_UPSIZE_FLUSH_EN
  localparam int BC = $clog2(RATIO + 1);

  logic          r_pend;
  logic [BC-1:0] r_beats;
  logic [CW:0]   w_fill;
  logic          w_fl;

  // Lanes held once this cycle's beat (if any) is included.
  assign w_fill  = w_in_ok ? ({1'b0, r_cnt} + 1'b1) : {1'b0, r_cnt};
  // A beat completing the word wins; an empty accumulator ignores flush.
  assign w_fl    = (flush | r_pend) & ~(w_in_ok & w_last)
                 & (w_fill != '0);
  assign w_fl_go = w_fl & w_free;
  assign w_ready = rst & (~w_last | w_free) & ~r_pend;

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= 1'b0;
      r_beats <= '0;
    end else begin
      r_pend <= w_fl & ~w_free;
      if (w_in_ok & w_last)
        r_beats <= BC'(RATIO);
      else if (w_fl_go)
        r_beats <= BC'(w_fill);
    end
  end

  assign out_beats = r_beats;
`else
  assign w_fl_go = 1'b0;
  assign w_ready = rst & (~w_last | w_free);
`endif

  // Final beat is only accepted when the out register can take it.
  assign w_load = (w_in_ok & w_last) | w_fl_go;

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_load | (r_valid & ~w_out_ok);
      if (w_load) begin
        r_data <= w_acc_n;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (w_in_ok) begin
        r_acc  <= w_acc_n;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign in_stream.ready  = w_ready;
  assign out_stream.valid = r_valid;
  assign out_stream.data  = r_data;
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: scoreboard bench for axis_upsizer at RATIO=4 and RATIO=1.
// Expected words are built from accepted beats and popped on output ok.
module tb_axis_upsizer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   g_wait = 0;
  int   n_rcv1 = 0;

  logic [31:0] q4[$];
  logic [7:0]  q1[$];
  int          ok_cyc[$];
  logic [31:0] m_acc;
  int          m_lane;

  always #5 clk = ~clk;

  Axis #(.W(8))  in4 ();
  Axis #(.W(32)) out4 ();
  Axis #(.W(8))  in1 ();
  Axis #(.W(8))  out1 ();

`ifdef AXIS_UPSIZE_FLUSH_EN
  logic       flush4 = 1'b0;
  logic       flush1 = 1'b0;
  logic [2:0] beats4;
  logic       beats1;
`endif

  axis_upsizer #(.BITWIDTH(8), .RATIO(4)) u_dut4 (
    .rd_clk     (clk),
    .rst        (rst),
`ifdef AXIS_UPSIZE_FLUSH_EN
    .flush      (flush4),
    .out_beats  (beats4),
`endif
    .in_stream  (in4),
    .out_stream (out4)
  );

  axis_upsizer #(.BITWIDTH(8), .RATIO(1)) u_dut1 (
    .rd_clk     (clk),
    .rst        (rst),
`ifdef AXIS_UPSIZE_FLUSH_EN
    .flush      (flush1),
    .out_beats  (beats1),
`endif
    .in_stream  (in1),
    .out_stream (out1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RATIO=4 scoreboard: pop on output ok, pack and push on input ok.
  initial begin
    m_acc  = '0;
    m_lane = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_acc  = '0;
        m_lane = 0;
      end else begin
        if (out4.valid && out4.ready) begin
          ok_cyc.push_back(cyc);
          if (q4.size() == 0) chk("sb4_empty", q4.size(), 1);
          else chk("word4", out4.data, q4.pop_front());
        end
        if (in4.valid && in4.ready) begin
          m_acc[m_lane*8 +: 8] = in4.data;
          m_lane++;
          if (m_lane == 4) begin
            q4.push_back(m_acc);
            m_acc  = '0;
            m_lane = 0;
          end
        end
`ifdef AXIS_UPSIZE_FLUSH_EN
        if (flush4 && m_lane > 0) begin
          q4.push_back(m_acc);
          m_acc  = '0;
          m_lane = 0;
        end
`endif
      end
    end
  end

  // RATIO=1 scoreboard: output sequence must equal input sequence.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (out1.valid && out1.ready) begin
        n_rcv1++;
        if (q1.size() == 0) chk("sb1_empty", q1.size(), 1);
        else chk("beat1", out1.data, q1.pop_front());
      end
      if (in1.valid && in1.ready) q1.push_back(in1.data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic put4(input logic [7:0] d);
    int t;
    t = 0;
    in4.valid = 1'b1;
    in4.data  = d;
    @(negedge clk);
    while (!in4.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    g_wait += t;
    chk("put4_acc", in4.ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sb[4];
    int acc;
    int sent;
    bit took;

    in4.valid = 0; in4.data = 0; out4.ready = 1;
    in1.valid = 0; in1.data = 0; out1.ready = 1;

    // reset state
    idle(2);
    @(negedge clk);
    chk("rst_v4", out4.valid, 0);
    chk("rst_d4", out4.data, 0);
    chk("rst_r4", in4.ready, 0);
    chk("rst_v1", out1.valid, 0);
    chk("rst_r1", in1.ready, 0);
    rst = 1'b1;
    idle(1);

    // single word, 1-cycle latency, valid for one cycle
    put4(8'h11); put4(8'h22); put4(8'h33); put4(8'h44);
    in4.valid = 0;
    chk("t1_v", out4.valid, 1);
    chk("t1_d", out4.data, 32'h44332211);
`ifdef AXIS_UPSIZE_FLUSH_EN
    chk("t1_beats", beats4, 4);
`endif
    idle(1);
    chk("t1_v_off", out4.valid, 0);

    // back-to-back words, no bubbles
    ok_cyc.delete();
    g_wait = 0;
    for (int i = 1; i <= 8; i++) put4(8'(i));
    in4.valid = 0;
    idle(2);
    chk("t2_nodrop", g_wait, 0);
    chk("t2_words", ok_cyc.size(), 2);
    if (ok_cyc.size() == 2) chk("t2_gap", ok_cyc[1] - ok_cyc[0], 4);

    // stall: exactly 3 further beats, word held stable
    out4.ready = 0;
    put4(8'h0a); put4(8'h0b); put4(8'h0c); put4(8'h0d);
    sb[0] = 8'h1a; sb[1] = 8'h1b; sb[2] = 8'h1c; sb[3] = 8'h1d;
    acc = 0;
    in4.data = sb[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = in4.valid && in4.ready;
      if (took) acc++;
      @(posedge clk);
      #1;
      if (took && acc < 4) in4.data = sb[acc];
    end
    chk("t3_cnt", acc, 3);
    chk("t3_rdy", in4.ready, 0);
    chk("t3_hold_v", out4.valid, 1);
    chk("t3_hold_d", out4.data, 32'h0d0c0b0a);
    out4.ready = 1;
    @(negedge clk);
    chk("t3_same_cyc", in4.ready, 1);
    @(posedge clk);
    #1;
    in4.valid = 0;
    chk("t3_v2", out4.valid, 1);
    chk("t3_d2", out4.data, 32'h1d1c1b1a);
    idle(2);

    // reset mid-word
    put4(8'h55); put4(8'h66);
    in4.valid = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_v", out4.valid, 0);
    chk("t4_d", out4.data, 0);
    chk("t4_r", in4.ready, 0);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    put4(8'hAA); put4(8'hBB); put4(8'hCC); put4(8'hDD);
    in4.valid = 0;
    chk("t4_v2", out4.valid, 1);
    chk("t4_d2", out4.data, 32'hDDCCBBAA);
    idle(2);

`ifdef AXIS_UPSIZE_FLUSH_EN
    // partial flush, then flush with nothing held
    put4(8'h11); put4(8'h22);
    in4.valid = 0;
    flush4 = 1;
    idle(1);
    flush4 = 0;
    chk("fl_v", out4.valid, 1);
    chk("fl_d", out4.data, 32'h00002211);
    chk("fl_beats", beats4, 2);
    idle(1);
    flush4 = 1;
    idle(1);
    flush4 = 0;
    chk("fl0_v", out4.valid, 0);
    idle(2);
    chk("fl0_v2", out4.valid, 0);
`endif

    // RATIO=1 random traffic
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      if (!in1.valid && $urandom_range(0, 1) == 1) begin
        in1.valid = 1;
        in1.data  = 8'($urandom);
      end
      out1.ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = in1.valid && in1.ready;
      if (took) sent++;
      @(posedge clk);
      #1;
      if (took) in1.valid = 0;
    end
    in1.valid  = 0;
    out1.ready = 1;
    idle(4);
    chk("r1_sent", sent, 1000);
    chk("r1_rcv", n_rcv1, 1000);
    chk("r1_left", q1.size(), 0);
    chk("r4_left", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
Read-domain stage that consumes the narrow AXI-stream produced by the CDC handshake block. It packs RATIO consecutive BITWIDTH-bit beats into one RATIO*BITWIDTH-bit word for the wide datapath downstream. The block is fully pipelined with one output register and sustains one input beat per cycle with no bubbles while the sink keeps ready high.

Parameters:
BITWIDTH, 1, width of each input beat
RATIO, 4, input beats per output word; legal range 1..64; elaboration error outside this range

Ports:
rd_clk  input  1  block clock; all logic is on its rising edge
rst  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is taken synchronously to rd_clk
in_stream  Axis.Slave  BITWIDTH  narrow input stream (valid, ready, data, ok = valid & ready)
out_stream  Axis.Master  RATIO*BITWIDTH  packed output stream (valid, ready, data, ok)

Behaviour:
- Reset values while rst=0:
  - out_stream.valid=0, out_stream.data=0.
  - Beat counter cnt=0 and accumulator acc=0.
  - in_stream.ready=0.
- Reset asserted mid-word discards any partially packed beats and any pending output word. The first beat after reset is lane 0.
- Lane order: beat k of a word lands in data[(k+1)*BITWIDTH-1 : k*BITWIDTH], so the first beat is the LSB lane.
- cnt width is max(1, $clog2(RATIO)); cnt counts 0..RATIO-1 and wraps to 0.
- Each in_stream.ok with cnt<RATIO-1: store the beat into acc lane cnt, then cnt++.
- in_stream.ok with cnt==RATIO-1 (the final beat):
  - Load the out register with acc plus this beat in the top lane.
  - Set out_stream.valid=1 on the next edge.
  - Set cnt=0 and clear acc to 0.
- Latency is 1 cycle from acceptance of the final beat to out_stream.valid=1.
- in_stream.ready (outside reset) = (cnt != RATIO-1) | ~out_stream.valid | out_stream.ready.
  - Partial beats are always accepted.
  - The final beat is accepted only if the out register is empty or draining this same cycle.
  - in_stream.ready must not depend on in_stream.valid.
- out_stream.valid holds high, with out_stream.data held stable, until out_stream.ok. After ok it clears unless a new word loads on the same edge.
- Simultaneous out_stream.ok and final-beat acceptance: the new word replaces the old one with valid staying 1. This gives back-to-back words with zero bubbles.
- RATIO=1 degenerates to a single-entry register slice: cnt is held at 0, every beat is a final beat, and throughput is 1 beat per cycle.
- Stall: with out_stream.valid=1 and out_stream.ready=0, the block accepts exactly RATIO-1 further beats, then holds in_stream.ready=0.

Optional Feature:
AXIS_UPSIZE_FLUSH_EN
- Enabled, the block adds two ports:
  - flush, input, 1 bit, single-cycle request.
  - out_beats, output, $clog2(RATIO+1) bits, number of valid lanes in the current output word; reset value 0.
- flush=1 with cnt>0 and the out register free or draining:
  - Emit acc as a partial word, with unused upper lanes forced to 0 and out_beats=cnt.
  - Set cnt=0 and clear acc to 0.
- flush on the same cycle as an in_stream.ok: the beat is included first, then the flush applies. If that beat completes the word, the result is a normal full word.
- flush with cnt=0 is ignored.
- flush while the out register is blocked: the request is held pending and in_stream.ready is forced to 0 until the flush is issued.
- Full words report out_beats=RATIO.
- Disabled: no extra ports. Partial words are only emitted on completion and only discarded by reset.

Test Plan:
- BITWIDTH=8, RATIO=4; send 0x11,0x22,0x33,0x44 with out_stream.ready=1 -> one cycle later out_stream.valid=1 and data=0x44332211 for exactly 1 cycle.
- Stream 8 beats 0x01..0x08 back-to-back with ready=1 -> words 0x04030201 then 0x08070605, in_stream.ready never drops, zero idle cycles between words.
- Hold out_stream.ready=0 after the first word -> 3 further beats accepted, then in_stream.ready=0, first word data stable; raise ready -> first word drains, 4th beat accepted the same cycle, second word valid on the next edge.
- Assert rst=0 after 2 beats, release, send 0xAA,0xBB,0xCC,0xDD -> data=0xDDCCBBAA with no stale lanes; all outputs 0 during reset.
- RATIO=1, BITWIDTH=8, random valid/ready over 1000 beats -> output sequence equals input sequence, no loss or duplication.
- AXIS_UPSIZE_FLUSH_EN defined: send 0x11,0x22 then pulse flush -> data=0x00002211 with out_beats=2; flush at cnt=0 produces no output.
